// File: rtl/deco_frame_tx.sv
// Frame initiator for the Deco turbo decoder port. It accepts one coded frame, serializes it into
// start/data beats, waits for done or a timeout, and hands the result back over valid/ready.
module deco_frame_tx #(
  parameter int BEAT_W    = 21,
  parameter int NUM_BEATS = 4,
  parameter int OUT_W     = 5,
  parameter int TIMEOUT   = 1023
) (
  input  logic                        clk_p_i,
  input  logic                        reset_p_i,
  input  logic                        frame_valid_i,
  input  logic [BEAT_W*NUM_BEATS-1:0] frame_i,
  output logic                        frame_ready_o,
  output logic                        deco_start_o,
  output logic [BEAT_W-1:0]           deco_data_o,
  input  logic [OUT_W-1:0]            deco_data_i,
  input  logic                        deco_done_i,
  output logic                        res_valid_o,
  output logic [OUT_W-1:0]            res_data_o,
  output logic                        res_timeout_o,
  input  logic                        res_ready_i,
  output logic                        busy_o,
  output logic                        err_o,
  output logic [15:0]                 frame_cnt_o
);

  localparam int BW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND   = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  logic [2:0]                           state_q, state_d;
  logic [NUM_BEATS-1:0][BEAT_W-1:0]     frame_q, frame_d;
  logic [BW-1:0]                        beat_idx_q, beat_idx_d;
  logic [TW-1:0]                        wait_cnt_q, wait_cnt_d;
  logic                                 ready_q, ready_d;
  logic                                 start_q, start_d;
  logic [BEAT_W-1:0]                    data_q, data_d;
  logic                                 res_valid_q, res_valid_d;
  logic [OUT_W-1:0]                     res_data_q, res_data_d;
  logic                                 res_to_q, res_to_d;
  logic                                 busy_q, busy_d;
  logic                                 err_q, err_d;
  logic [15:0]                          cnt_q, cnt_d;

  // Every output register is computed together with the next state so the outputs
  // line up with the state they describe in the same cycle.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    frame_d     = frame_q;
    beat_idx_d  = beat_idx_q;
    wait_cnt_d  = wait_cnt_q;
    ready_d     = ready_q;
    start_d     = start_q;
    data_d      = data_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_to_d    = res_to_q;
    cnt_d       = cnt_q;
    err_d       = err_q | (deco_done_i && (state_q != S_WAIT));

    case (state_q)
      S_IDLE: begin
        if (frame_valid_i && ready_q) begin
          frame_d    = frame_i;
          beat_idx_d = '0;
          start_d    = 1'b1;
          data_d     = frame_i[BEAT_W-1:0];
          ready_d    = 1'b0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (beat_idx_q == LAST_BEAT) begin
          state_d = S_HOLD;
        end else begin
          beat_idx_d = beat_idx_q + BW'(1);
          data_d     = frame_q[beat_idx_d];
        end
      end
      S_HOLD: begin
        start_d    = 1'b0;
        data_d     = '0;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // done is tested first so it wins over a simultaneous timeout
        if (deco_done_i) begin
          res_data_d  = deco_data_i;
          res_to_d    = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else if (wait_cnt_q == LAST_WAIT) begin
          res_data_d  = '0;
          res_to_d    = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      S_RESULT: begin
        if (res_valid_q && res_ready_i) begin
          cnt_d       = cnt_q + 16'd1;
          res_valid_d = 1'b0;
          ready_d     = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        ready_d = 1'b1;
        start_d = 1'b0;
        data_d  = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_p_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset_p_i) begin
      state_q     <= S_IDLE;
      // NOTE: the frame buffer is an ordinary register here, so it is cleared like the rest.
      frame_q     <= '0;
      beat_idx_q  <= '0;
      wait_cnt_q  <= '0;
      ready_q     <= 1'b1;
      start_q     <= 1'b0;
      data_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_to_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      beat_idx_q  <= beat_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      ready_q     <= ready_d;
      start_q     <= start_d;
      data_q      <= data_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_to_q    <= res_to_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign frame_ready_o = ready_q;
  assign deco_start_o  = start_q;
  assign deco_data_o   = data_q;
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = res_data_q;
  assign res_timeout_o = res_to_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign frame_cnt_o   = cnt_q;

endmodule
